// File: rtl/cpu_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the execute-side controller:
// FSM state encoding, next-PC select codes and the halt opcode.
package cpu_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Next-PC select codes driven on SPC by the controller
  localparam logic [1:0] SPC_SEQ  = 2'd0;
  localparam logic [1:0] SPC_JMP  = 2'd1;
  localparam logic [1:0] SPC_RET  = 2'd2;
  localparam logic [1:0] SPC_LOOP = 2'd3;

  localparam logic [5:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/cpu_ret_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; push and pop together replace the top in place. A pop on an empty
// stack is ignored here (the caller decides what address to use).
// DEPTH must be a power of two, at least 2, so the pointer wraps naturally.
module cpu_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_sp_inc;
  logic          w_pop;

  assign w_sp_inc = r_sp + 1'b1;
  assign w_pop    = pop && !empty;
  assign top      = r_mem[r_sp];
  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);

  // Pointer, depth and storage update; r_sp always addresses the top entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push && w_pop) begin
      r_mem[r_sp] <= push_data;
    end else if (push) begin
      r_sp            <= w_sp_inc;
      r_mem[w_sp_inc] <= push_data;
      if (!full) r_count <= r_count + 1'b1;
    end else if (w_pop) begin
      r_sp    <= r_sp - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: reads instruction memory at PC, holds the word for
// the execute side until acknowledged, then steps PC by the controller's
// SPC select, with a small return stack for call/return.
//
// Handshakes: memory side is request/ready -- mem_rd and mem_addr are held
// until a cycle with mem_ready=1, when mem_data is captured. Execute side is
// valid/ack -- instr, Opcode and pc are stable while instr_valid=1 and the
// instruction transfers on the cycle where instr_valid and instr_ack are both
// high; SPC, target and push_ret are only looked at in that cycle.
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int            STK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_data,
  output logic [5:0]    Opcode,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ack,
  input  logic [1:0]    SPC,
  input  logic [AW-1:0] target,
  input  logic          push_ret,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          stk_err,
  output fetch_state_e  dbg_state
);

  fetch_state_e  r_state, w_next_state;
  // Clear while in reset so the first read request waits for a clock edge
  logic          r_armed;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_instr;
  logic          r_stk_err;

  logic [AW-1:0] w_pc_inc, w_next_pc, w_stk_top;
  logic          w_accept, w_ack, w_push, w_pop, w_stk_full, w_stk_empty;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_accept = mem_rd && mem_ready;
  assign w_ack    = (r_state == ST_ISSUE) && instr_ack;
  assign w_push   = w_ack && push_ret;
  assign w_pop    = w_ack && (SPC == SPC_RET);

  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign Opcode    = r_instr[DW-1 -: 6];
  assign stk_err   = r_stk_err;
  assign dbg_state = r_state;

  cpu_ret_stack #(.DEPTH(STK_DEPTH), .W(AW)) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_stk_top),
    .full      (w_stk_full),
    .empty     (w_stk_empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a zero-wait reply in FETCH goes straight to ISSUE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: if (r_armed) w_next_state = mem_ready ? ST_ISSUE : ST_WAIT;
      ST_WAIT:  if (mem_ready) w_next_state = ST_ISSUE;
      ST_ISSUE: if (instr_ack) w_next_state = (Opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      default:  w_next_state = ST_HALT;
    endcase
  end

  // Outputs decoded from state; read request and issue are mutually exclusive
  always_comb begin
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: mem_rd      = r_armed;
      ST_WAIT:  mem_rd      = 1'b1;
      ST_ISSUE: instr_valid = 1'b1;
      default:  halted      = 1'b1;
    endcase
  end

  // Next-PC select; an empty-stack return falls back to the reset address
  always_comb begin
    case (SPC)
      SPC_JMP: w_next_pc = target;
      SPC_RET: w_next_pc = w_stk_empty ? RESET_PC : w_stk_top;
      default: w_next_pc = w_pc_inc;
    endcase
  end

  // Datapath registers: arm flag, PC, captured instruction, sticky stack error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed   <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) r_instr <= mem_data;
      if (w_ack)    r_pc    <= w_next_pc;
      if ((w_pop && w_stk_empty) || (w_push && !w_pop && w_stk_full))
        r_stk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: the bench plays instruction memory and
// the execute-side controller, with hand-computed addresses and flags.
module tb_cpu_fetch_unit;
  import cpu_fetch_unit_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk, rst;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_ready;
  logic [DW-1:0] mem_data;
  logic [5:0]    Opcode;
  logic [DW-1:0] instr;
  logic          instr_valid, instr_ack;
  logic [1:0]    SPC;
  logic [AW-1:0] target;
  logic          push_ret;
  logic [AW-1:0] pc;
  logic          halted, stk_err;
  fetch_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  cpu_fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(16'h0000), .STK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_data(mem_data), .Opcode(Opcode), .instr(instr),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .SPC(SPC), .target(target),
    .push_ret(push_ret), .pc(pc), .halted(halted), .stk_err(stk_err),
    .dbg_state(dbg_state)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory driver: wait for the request, check address, answer after `waits` cycles
  task automatic do_read(input string tag, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int waits);
    int rd_cycles;
    for (int i = 0; i < 10 && !mem_rd; i++) step();
    check({tag, ".rd"}, 32'(mem_rd), 32'd1);
    check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    check({tag, ".excl"}, 32'(instr_valid), 32'd0);
    rd_cycles = 1;
    for (int i = 0; i < waits; i++) begin
      step();
      if (mem_rd) rd_cycles++;
    end
    if (waits > 0) begin
      check({tag, ".rd_held"}, 32'(rd_cycles), 32'(waits + 1));
      check({tag, ".valid_pre"}, 32'(instr_valid), 32'd0);
    end
    mem_data  = data;
    mem_ready = 1'b1;
    exp_q.push_back(data);
    step();
    mem_ready = 1'b0;
    mem_data  = $urandom();
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".instr"}, instr, exp_q.pop_front());
    check({tag, ".rd_off"}, 32'(mem_rd), 32'd0);
    check({tag, ".pc"}, 32'(pc), 32'(addr));
  endtask

  // Controller driver: one-cycle ack with the given next-PC controls
  task automatic do_ack(input string tag, input logic [1:0] spc, input logic [AW-1:0] tgt,
                        input logic push, input logic exp_halt);
    SPC       = spc;
    target    = tgt;
    push_ret  = push;
    instr_ack = 1'b1;
    step();
    instr_ack = 1'b0;
    push_ret  = 1'b0;
    SPC       = 2'($urandom_range(0, 3));
    target    = AW'($urandom_range(0, 16'hFFFF));
    check({tag, ".ack_nvalid"}, 32'(instr_valid), 32'd0);
    check({tag, ".ack_halted"}, 32'(halted), 32'(exp_halt));
    check({tag, ".ack_rd"}, 32'(mem_rd), 32'(!exp_halt));
  endtask

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {6'h0A, 10'h000, a};
  endfunction

  // Directed sequence
  initial begin
    int busy;
    logic [AW-1:0] pop_exp [5];
    pop_exp = '{16'd11, 16'd10, 16'd9, 16'd8, 16'd0};
    rst = 1'b1; mem_ready = 1'b0; mem_data = '0; instr_ack = 1'b0;
    SPC = SPC_SEQ; target = '0; push_ret = 1'b0;

    // Reset state
    step(); step();
    check("rst.mem_rd", 32'(mem_rd), 32'd0);
    check("rst.valid", 32'(instr_valid), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.stk_err", 32'(stk_err), 32'd0);
    check("rst.pc", 32'(pc), 32'h0);
    check("rst.instr", instr, 32'h0);
    check("rst.state", 32'(dbg_state), 32'(ST_FETCH));
    rst = 1'b0;
    check("rst.no_early_rd", 32'(mem_rd), 32'd0);
    step();
    check("rst.first_rd", 32'(mem_rd), 32'd1);

    // Zero-wait fetch, sequential step
    do_read("t1", 16'h0000, 32'h0400_0000, 0);
    check("t1.opcode", 32'(Opcode), 32'h01);
    do_ack("t1", SPC_SEQ, 16'h0, 1'b0, 1'b0);

    // Three wait cycles, then hold ISSUE one cycle without ack
    do_read("t2", 16'h0001, 32'h0800_0001, 3);
    step();
    check("t2.hold_valid", 32'(instr_valid), 32'd1);
    check("t2.hold_opcode", 32'(Opcode), 32'h02);
    check("t2.hold_pc", 32'(pc), 32'h1);
    do_ack("t2", SPC_JMP, 16'h0005, 1'b0, 1'b0);

    // Call and return
    do_read("t3.a", 16'h0005, word_at(16'h0005), 0);
    do_ack("t3.call", SPC_JMP, 16'h0020, 1'b1, 1'b0);
    do_read("t3.b", 16'h0020, word_at(16'h0020), 0);
    do_ack("t3.ret", SPC_RET, 16'h0, 1'b0, 1'b0);
    do_read("t3.c", 16'h0006, word_at(16'h0006), 0);
    check("t3.stk_err", 32'(stk_err), 32'd0);

    // Five pushes into a four-entry stack, then five pops
    for (int i = 0; i < 5; i++) begin
      do_ack("t4.push", SPC_SEQ, 16'h0, 1'b1, 1'b0);
      if (i == 3) check("t4.no_err_at_4", 32'(stk_err), 32'd0);
      do_read("t4.seq", AW'(7 + i), word_at(AW'(7 + i)), 0);
    end
    check("t4.overflow", 32'(stk_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      do_ack("t4.pop", SPC_RET, 16'h0, 1'b0, 1'b0);
      do_read("t4.ret", pop_exp[i], word_at(pop_exp[i]), 0);
    end

    // Halt and recovery by reset
    do_ack("t5.seq", SPC_SEQ, 16'h0, 1'b0, 1'b0);
    do_read("t5.halt", 16'h0001, 32'hFC00_0000, 0);
    check("t5.opcode", 32'(Opcode), 32'h3F);
    do_ack("t5.halt", SPC_SEQ, 16'h0, 1'b0, 1'b1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
      if (mem_rd || instr_valid || !halted) busy++;
    end
    mem_ready = 1'b0;
    check("t5.stays_halted", 32'(busy), 32'd0);
    rst = 1'b1;
    #1;
    check("t5.rst_halted", 32'(halted), 32'd0);
    check("t5.rst_stk_err", 32'(stk_err), 32'd0);
    check("t5.rst_pc", 32'(pc), 32'h0);
    step();
    rst = 1'b0;
    do_read("t5.restart", 16'h0000, word_at(16'h0000), 0);

    // Reset in the middle of a waited read
    do_ack("t6.jmp", SPC_JMP, 16'h0030, 1'b0, 1'b0);
    step();
    check("t6.wait_state", 32'(dbg_state), 32'(ST_WAIT));
    check("t6.wait_addr", 32'(mem_addr), 32'h30);
    #3;
    rst = 1'b1;
    #1;
    check("t6.async_rd", 32'(mem_rd), 32'd0);
    check("t6.async_state", 32'(dbg_state), 32'(ST_FETCH));
    mem_data  = 32'hDEAD_BEEF;
    mem_ready = 1'b1;
    step();
    rst = 1'b0;
    check("t6.late_valid", 32'(instr_valid), 32'd0);
    check("t6.late_rd", 32'(mem_rd), 32'd0);
    mem_ready = 1'b0;
    step();
    check("t6.late_ignored", 32'(instr_valid), 32'd0);
    do_read("t6.refetch", 16'h0000, 32'h1000_0000, 0);

    // Underflow, simultaneous push+pop, LOOP select and PC wrap
    do_ack("t7.underflow", SPC_RET, 16'h0, 1'b0, 1'b0);
    check("t7.stk_err", 32'(stk_err), 32'd1);
    do_read("t7.a", 16'h0000, word_at(16'h0000), 0);
    do_ack("t7.call", SPC_SEQ, 16'h0, 1'b1, 1'b0);
    do_read("t7.b", 16'h0001, word_at(16'h0001), 0);
    do_ack("t7.swap", SPC_RET, 16'h0, 1'b1, 1'b0);
    do_read("t7.c", 16'h0001, word_at(16'h0001), 0);
    do_ack("t7.ret", SPC_RET, 16'h0, 1'b0, 1'b0);
    do_read("t7.d", 16'h0002, word_at(16'h0002), 0);
    do_ack("t7.jmp", SPC_JMP, 16'hFFFF, 1'b0, 1'b0);
    do_read("t7.e", 16'hFFFF, word_at(16'hFFFF), 0);
    do_ack("t7.loop", SPC_LOOP, 16'h1234, 1'b0, 1'b0);
    do_read("t7.wrap", 16'h0000, word_at(16'h0000), 0);
    do_ack("t7.empty", SPC_RET, 16'h0, 1'b0, 1'b0);
    do_read("t7.f", 16'h0000, word_at(16'h0000), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 SHALL have parameter AW, default 16, meaning program-address width.
REQ-002 SHALL have parameter DW, default 32, meaning instruction-word width; Opcode is bits [DW-1:DW-6].
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 SHALL have parameter STK_DEPTH, default 4, meaning return-stack entries (power of two).
REQ-005 SHALL have port clk  in  1  single system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port mem_addr  out  AW  instruction memory address, equal to PC while mem_rd=1.
REQ-008 SHALL have port mem_rd  out  1  instruction read request.
REQ-009 SHALL have port mem_ready  in  1  read data valid this cycle.
REQ-010 SHALL have port mem_data  in  DW  instruction word.
REQ-011 SHALL have port Opcode  out  6  opcode field of the issued instruction, for the execute-side controller.
REQ-012 SHALL have port instr  out  DW  full issued instruction word.
REQ-013 SHALL have port instr_valid  out  1  instr/Opcode valid.
REQ-014 SHALL have port instr_ack  in  1  execute side consumes the instruction; SPC, target and push_ret are sampled in this cycle.
REQ-015 SHALL have port SPC  in  2  next-PC select from the controller.
REQ-016 SHALL have port target  in  AW  jump/branch destination.
REQ-017 SHALL have port push_ret  in  1  call: push PC+1 onto the return stack.
REQ-018 SHALL have port pc  out  AW  address of the issued instruction.
REQ-019 SHALL have port halted  out  1  fetch stopped by the halt opcode.
REQ-020 SHALL have port stk_err  out  1  sticky return-stack overflow or underflow.

Function
REQ-021 SHALL implement the FSM states FETCH, WAIT, ISSUE and HALT.
REQ-022 SHALL, in FETCH, drive mem_rd=1 and mem_addr=PC for one cycle, then enter WAIT.
REQ-023 SHALL hold mem_rd=1 and mem_addr=PC in WAIT until mem_ready=1, then latch mem_data into instr and enter ISSUE; a same-cycle mem_ready in FETCH is also accepted.
REQ-024 SHALL hold instr_valid=1 with instr, Opcode and pc stable in ISSUE until instr_ack=1.
REQ-025 SHALL compute the next PC on the instr_ack cycle: SPC=0 gives PC+1; SPC=1 gives target; SPC=2 gives the popped stack top; SPC=3 gives PC+1.
REQ-026 SHALL wrap PC+1 modulo 2^AW with no flag.
REQ-027 SHALL push PC+1 on ack when push_ret=1; when the stack is full, overwrite the oldest entry and set stk_err.
REQ-028 SHALL, on a pop with an empty stack, use RESET_PC as the next PC and set stk_err.
REQ-029 SHALL, when push_ret=1 and SPC=2 occur together, replace the stack top with PC+1 after reading the popped value, leaving depth unchanged.
REQ-030 SHALL, on ack of Opcode 6'h3F, enter HALT: halted=1, mem_rd=0, instr_valid=0 until reset.
REQ-031 SHALL drop instr_valid the cycle after the ack and re-enter FETCH, giving a minimum of 2 cycles between issues with zero-wait memory.
REQ-032 SHALL keep instr_valid=0 whenever mem_rd=1, and never assert both.

Reset
REQ-033 SHALL, on rst asynchronously, set state=FETCH, PC=RESET_PC, stack depth=0, instr=0, mem_rd=0, instr_valid=0, halted=0 and stk_err=0.
REQ-034 SHALL cause a reset in WAIT or ISSUE to abandon the pending read or instruction, and SHALL issue the first mem_rd on the first clock edge after rst deasserts.

Structure
REQ-035 SHALL place the FSM state encoding, the SPC codes (SPC_SEQ=0, SPC_JMP=1, SPC_RET=2, SPC_LOOP=3) and OP_HALT=6'h3F in a shared package, also used by the controller.
REQ-036 SHALL implement the return stack as the sub-module cpu_ret_stack (push, pop, top, full, empty).

Verification
REQ-037 SHALL cover: reset, memory returns 0x04000000 after 0 wait cycles, ack with SPC=0 -> mem_addr sequence 0,1; Opcode=0x01; pc=0.
REQ-038 SHALL cover: mem_ready delayed 3 cycles -> mem_rd held 4 cycles, instr_valid rises the cycle after mem_ready.
REQ-039 SHALL cover: at PC=5, ack with push_ret=1 and SPC=1, target=0x20; later ack with SPC=2 -> fetches 0x20 then 6.
REQ-040 SHALL cover: five pushes with STK_DEPTH=4 -> stk_err=1; the next four pops return the last four pushes; a fifth pop goes to RESET_PC.
REQ-041 SHALL cover: ack of Opcode 0x3F -> halted=1, mem_rd stays 0 for 20 cycles; rst -> fetch restarts at RESET_PC.
REQ-042 SHALL cover: rst asserted mid-WAIT -> mem_rd=0 immediately, not on the next edge; a late mem_ready is ignored.
